calculadora_param: RTL and testbench

Parametrised BCD calculator core for the board-level demo: two unsigned operands from switches, a power button and three operation buttons (add, subtract, multiply), operand and result digits driven to active-low seven-segment displays. It generalises the fixed 2-digit/4-digit calculator with configurable widths and digit counts, debounced edge-detected buttons, signed subtraction display and a sequential binary-to-BCD converter.

---
 rtl/calculadora_param.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_calculadora_param.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculadora_param.sv
// calculadora_param
// Parametrised BCD calculator core for the board demo. Two operands come
// from switches and are clamped to 10^DIGITS_IN-1. A power button and three
// operation buttons (add, subtract, multiply) select the mode. Operands and
// result are converted to BCD by shift-add-3 converters, one bit per cycle.
// The digits are driven to active-low seven-segment displays.
//
// Optional feature macro: CALC_DEBOUNCE_EN
//   defined   : a button level counts only after DEB_CYCLES stable samples.
//   undefined : the synchronised level feeds the press edge detector directly.
//
// Ports
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset (assert async, release sync)
//   botao        in   power button, active-low
//   botaoSOMA    in   add button, active-low
//   botaoSUB     in   subtract button, active-low
//   botaoMULT    in   multiply button, active-low
//   numero0      in   operand A (W bits)
//   numero1      in   operand B (W bits)
//   op0_seg      out  operand A digits, 7 bits per digit, digit 0 = units,
//                     bit 7k = segment a ... bit 7k+6 = segment g, active-low
//   op1_seg      out  operand B digits, same packing
//   res_seg      out  result digits (DIGITS_OUT), same packing
//   busy         out  BCD conversion in progress
//   o_dbg_mode   out  current mode FSM state (OFF=0 IDLE=1 SOMA=2 SUB=3 MULT=4)
module calculadora_param #(
  parameter int W          = 7,
  parameter int DIGITS_IN  = 2,
  parameter int DIGITS_OUT = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    botao,
  input  logic                    botaoSOMA,
  input  logic                    botaoSUB,
  input  logic                    botaoMULT,
  input  logic [W-1:0]            numero0,
  input  logic [W-1:0]            numero1,
  output logic [7*DIGITS_IN-1:0]  op0_seg,
  output logic [7*DIGITS_IN-1:0]  op1_seg,
  output logic [7*DIGITS_OUT-1:0] res_seg,
  output logic                    busy,
  output logic [2:0]              o_dbg_mode
);

  if (DIGITS_OUT < 2 * DIGITS_IN || DEB_CYCLES < 1) begin : g_param_check
    $error("calculadora_param: DIGITS_OUT must be >= 2*DIGITS_IN and DEB_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    MODE_OFF  = 3'd0,
    MODE_IDLE = 3'd1,
    MODE_SOMA = 3'd2,
    MODE_SUB  = 3'd3,
    MODE_MULT = 3'd4
  } mode_t;

  localparam int MAXV = 10 ** DIGITS_IN - 1;
  localparam int RW   = 2 * W;
  localparam int BW   = 4 * DIGITS_OUT;
  localparam int NW   = $clog2(RW + 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // ---------------------------------------------------------------------
  // Reset: asserted asynchronously, released on a clock edge.
  // ---------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // ---------------------------------------------------------------------
  // Buttons: index 0 power, 1 SOMA, 2 SUB, 3 MULT. Released level is 1.
  // ---------------------------------------------------------------------
  logic [3:0] w_btn_pin;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_lvl_d;
  logic [3:0] w_lvl;
  logic [3:0] w_press;

  assign w_btn_pin = {botaoMULT, botaoSUB, botaoSOMA, botao};

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_lvl_d <= '1;
    end else begin
      r_sync1 <= w_btn_pin;
      r_sync2 <= r_sync1;
      r_lvl_d <= w_lvl;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] r_deb_cnt [4];
  logic [3:0]    r_deb_lvl;

  // The filtered level follows the synchronised level only after it has
  // disagreed for DEB_CYCLES consecutive samples; any agreement restarts.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_deb_lvl <= '1;
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb_lvl[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
          r_deb_lvl[i] <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_lvl = r_deb_lvl;
`else
  assign w_lvl = r_sync2;
`endif

  // Single-cycle pulse on the filtered high-to-low transition.
  assign w_press = r_lvl_d & ~w_lvl;

  // ---------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------
  mode_t r_mode;
  mode_t w_mode_next;

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) r_mode <= MODE_OFF;
    else          r_mode <= w_mode_next;
  end

  // Power wins over operation buttons; among those SOMA > SUB > MULT.
  always_comb begin
    w_mode_next = r_mode;
    if (w_press[0]) begin
      w_mode_next = (r_mode == MODE_OFF) ? MODE_IDLE : MODE_OFF;
    end else if (r_mode != MODE_OFF) begin
      if (w_press[1])      w_mode_next = (r_mode == MODE_SOMA) ? MODE_IDLE : MODE_SOMA;
      else if (w_press[2]) w_mode_next = (r_mode == MODE_SUB)  ? MODE_IDLE : MODE_SUB;
      else if (w_press[3]) w_mode_next = (r_mode == MODE_MULT) ? MODE_IDLE : MODE_MULT;
    end
  end

  assign o_dbg_mode = r_mode;

  // ---------------------------------------------------------------------
  // Operands (clamped, registered every cycle) and arithmetic
  // ---------------------------------------------------------------------
  logic [W-1:0]  w_a_clamp;
  logic [W-1:0]  w_b_clamp;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [RW-1:0] w_res;
  logic          w_neg;

  assign w_a_clamp = (int'(numero0) > MAXV) ? W'(MAXV) : numero0;
  assign w_b_clamp = (int'(numero1) > MAXV) ? W'(MAXV) : numero1;

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= w_a_clamp;
      r_b <= w_b_clamp;
    end
  end

  always_comb begin
    w_res = '0;
    w_neg = 1'b0;
    case (r_mode)
      MODE_SOMA: w_res = RW'(r_a) + RW'(r_b);
      MODE_SUB: begin
        if (r_a < r_b) begin
          w_res = RW'(r_b - r_a);
          w_neg = 1'b1;
        end else begin
          w_res = RW'(r_a - r_b);
        end
      end
      MODE_MULT: w_res = RW'(r_a) * RW'(r_b);
      default:   w_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Double-dabble converters: operands and result run in lock step over
  // 2W cycles, so all three channels finish together.
  // ---------------------------------------------------------------------
  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] bcd, input logic bit_in);
    logic [BW-1:0] adj;
    adj = bcd;
    for (int d = 0; d < DIGITS_OUT; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    return {adj[BW-2:0], bit_in};
  endfunction

  logic [W-1:0]  r_cap_a;
  logic [W-1:0]  r_cap_b;
  mode_t         r_cap_mode;
  logic          r_cap_neg;
  logic [RW-1:0] r_sh_a;
  logic [RW-1:0] r_sh_b;
  logic [RW-1:0] r_sh_r;
  logic [BW-1:0] r_bcd_a;
  logic [BW-1:0] r_bcd_b;
  logic [BW-1:0] r_bcd_r;
  logic [NW-1:0] r_bit_cnt;
  logic          r_busy;
  logic          r_done;
  logic          w_change;

  assign w_change = (r_a != r_cap_a) || (r_b != r_cap_b) || (r_mode != r_cap_mode);

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cap_a    <= '0;
      r_cap_b    <= '0;
      r_cap_mode <= MODE_OFF;
      r_cap_neg  <= 1'b0;
      r_sh_a     <= '0;
      r_sh_b     <= '0;
      r_sh_r     <= '0;
      r_bcd_a    <= '0;
      r_bcd_b    <= '0;
      r_bcd_r    <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_mode == MODE_OFF) begin
        // Discard any conversion in flight; leaving OFF restarts one.
        r_busy     <= 1'b0;
        r_cap_mode <= MODE_OFF;
      end else if (w_change) begin
        // New inputs (also aborts a running conversion).
        r_cap_a    <= r_a;
        r_cap_b    <= r_b;
        r_cap_mode <= r_mode;
        r_cap_neg  <= w_neg;
        r_sh_a     <= RW'(r_a);
        r_sh_b     <= RW'(r_b);
        r_sh_r     <= w_res;
        r_bcd_a    <= '0;
        r_bcd_b    <= '0;
        r_bcd_r    <= '0;
        r_bit_cnt  <= '0;
        r_busy     <= 1'b1;
      end else if (r_busy) begin
        r_bcd_a   <= dd_step(r_bcd_a, r_sh_a[RW-1]);
        r_bcd_b   <= dd_step(r_bcd_b, r_sh_b[RW-1]);
        r_bcd_r   <= dd_step(r_bcd_r, r_sh_r[RW-1]);
        r_sh_a    <= {r_sh_a[RW-2:0], 1'b0};
        r_sh_b    <= {r_sh_b[RW-2:0], 1'b0};
        r_sh_r    <= {r_sh_r[RW-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + NW'(1);
        if (r_bit_cnt == NW'(RW - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;

  // ---------------------------------------------------------------------
  // Display registers: loaded atomically from the finished BCD digits.
  // ---------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  logic [7*DIGITS_IN-1:0]  w_op0_next;
  logic [7*DIGITS_IN-1:0]  w_op1_next;
  logic [7*DIGITS_OUT-1:0] w_res_next;
  logic [7*DIGITS_IN-1:0]  r_op0_seg;
  logic [7*DIGITS_IN-1:0]  r_op1_seg;
  logic [7*DIGITS_OUT-1:0] r_res_seg;

  always_comb begin
    w_op0_next = '1;
    w_op1_next = '1;
    w_res_next = '1;
    for (int k = 0; k < DIGITS_IN; k++) begin
      w_op0_next[7*k +: 7] = seg7(r_bcd_a[4*k +: 4]);
      w_op1_next[7*k +: 7] = seg7(r_bcd_b[4*k +: 4]);
    end
    if (r_cap_mode != MODE_IDLE) begin
      for (int k = 0; k < DIGITS_OUT; k++) begin
        w_res_next[7*k +: 7] = seg7(r_bcd_r[4*k +: 4]);
      end
      // Negative difference: most-significant digit becomes a minus sign.
      if (r_cap_mode == MODE_SUB && r_cap_neg) begin
        w_res_next[7*(DIGITS_OUT-1) +: 7] = SEG_MINUS;
      end
    end
  end

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_op0_seg <= '1;
      r_op1_seg <= '1;
      r_res_seg <= '1;
    end else if (r_mode == MODE_OFF) begin
      r_op0_seg <= '1;
      r_op1_seg <= '1;
      r_res_seg <= '1;
    end else if (r_done) begin
      r_op0_seg <= w_op0_next;
      r_op1_seg <= w_op1_next;
      r_res_seg <= w_res_next;
    end
  end

  assign op0_seg = r_op0_seg;
  assign op1_seg = r_op1_seg;
  assign res_seg = r_res_seg;

endmodule

// File: tb/tb_calculadora_param.sv
`timescale 1ns/1ps
// Bench for calculadora_param. Expected displays come from an integer model
// (clamp, arithmetic, decimal digits, segment table) and go through exp_q.
module tb_calculadora_param;

  localparam int W    = 7;
  localparam int DI   = 2;
  localparam int DO   = 4;
  localparam int DEB  = 4;
  localparam int RW   = 2 * W;
  localparam int DW   = 7 * (2 * DI + DO);
  localparam int MAXV = 10 ** DI - 1;

  localparam int M_OFF  = 0;
  localparam int M_IDLE = 1;
  localparam int M_SOMA = 2;
  localparam int M_SUB  = 3;
  localparam int M_MULT = 4;

`ifdef CALC_DEBOUNCE_EN
  localparam int LAT         = 2 + DEB + 1;
  localparam int GLITCH_MODE = M_MULT;
`else
  localparam int LAT         = 3;
  localparam int GLITCH_MODE = M_SOMA;
`endif
  localparam int HOLD = LAT + 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic b_pwr  = 1'b1;
  logic b_soma = 1'b1;
  logic b_sub  = 1'b1;
  logic b_mult = 1'b1;
  logic [W-1:0] num0 = '0;
  logic [W-1:0] num1 = '0;
  logic [7*DI-1:0] op0;
  logic [7*DI-1:0] op1;
  logic [7*DO-1:0] res;
  logic            busy;
  logic [2:0]      mode;
  logic [DW-1:0]   obs;

  always #5 clk = ~clk;

  calculadora_param #(.W(W), .DIGITS_IN(DI), .DIGITS_OUT(DO), .DEB_CYCLES(DEB)) dut (
    .clock(clk), .reset_n(rst_n), .botao(b_pwr), .botaoSOMA(b_soma),
    .botaoSUB(b_sub), .botaoMULT(b_mult), .numero0(num0), .numero1(num1),
    .op0_seg(op0), .op1_seg(op1), .res_seg(res), .busy(busy), .o_dbg_mode(mode)
  );

  assign obs = {res, op1, op0};

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- model ----------------
  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [DW-1:0] model(int a, int b, int m);
    logic [7*DI-1:0] s0;
    logic [7*DI-1:0] s1;
    logic [7*DO-1:0] sr;
    int ca, cb, r, v;
    bit neg;
    s0 = '1; s1 = '1; sr = '1; neg = 0; r = 0;
    ca = (a > MAXV) ? MAXV : a;
    cb = (b > MAXV) ? MAXV : b;
    if (m != M_OFF) begin
      v = ca; for (int k = 0; k < DI; k++) begin s0[7*k +: 7] = seg_of(v % 10); v = v / 10; end
      v = cb; for (int k = 0; k < DI; k++) begin s1[7*k +: 7] = seg_of(v % 10); v = v / 10; end
      case (m)
        M_SOMA: r = ca + cb;
        M_SUB:  begin if (ca < cb) begin r = cb - ca; neg = 1; end else r = ca - cb; end
        M_MULT: r = ca * cb;
        default: r = 0;
      endcase
      if (m != M_IDLE) begin
        v = r; for (int k = 0; k < DO; k++) begin sr[7*k +: 7] = seg_of(v % 10); v = v / 10; end
        if (m == M_SUB && neg) sr[7*(DO-1) +: 7] = 7'b0111111;
      end
    end
    return {sr, s1, s0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_btn(int idx, logic v);
    case (idx)
      0: b_pwr = v;
      1: b_soma = v;
      2: b_sub = v;
      default: b_mult = v;
    endcase
  endtask

  task automatic press(int idx);
    set_btn(idx, 1'b0); tick(HOLD);
    set_btn(idx, 1'b1); tick(HOLD);
  endtask

  task automatic wait_settle(string name);
    int quiet = 0;
    bit ok = 0;
    for (int c = 0; c < 400; c++) begin
      tick(1);
      if (busy === 1'b0) quiet++; else quiet = 0;
      if (quiet >= 4) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_settle: busy did not stay low within 400 cycles", name); end
  endtask

  task automatic wait_busy(string name);
    bit ok = 0;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      if (busy === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_busy: busy never rose within 50 cycles", name); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; tick(3);
    checks++; if (op0 !== '1)  begin errors++; $display("FAIL reset_op0: got %h want all ones", op0); end
    checks++; if (op1 !== '1)  begin errors++; $display("FAIL reset_op1: got %h want all ones", op1); end
    checks++; if (res !== '1)  begin errors++; $display("FAIL reset_res: got %h want all ones", res); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mode !== 3'(M_OFF)) begin errors++; $display("FAIL reset_mode: got %0d want %0d", mode, M_OFF); end
    rst_n = 1'b1; tick(4);
    checks++; if (obs !== '1) begin errors++; $display("FAIL reset_release_blank: got %h want all ones", obs); end
  endtask

  task automatic test_power_latency();
    logic [DW-1:0] e;
    num0 = 7'd45; num1 = 7'd38;
    exp_q.push_back(model(45, 38, M_IDLE));
    set_btn(0, 1'b0);
    tick(LAT - 1);
    checks++; if (mode !== 3'(M_OFF)) begin errors++; $display("FAIL latency_early: mode %0d want %0d", mode, M_OFF); end
    tick(1);
    checks++; if (mode !== 3'(M_IDLE)) begin errors++; $display("FAIL latency_on: mode %0d want %0d", mode, M_IDLE); end
    tick(HOLD - LAT); set_btn(0, 1'b1); tick(HOLD);
    wait_settle("idle");
    e = exp_q.pop_front();
    checks++; if (obs !== e) begin errors++; $display("FAIL idle_disp: got %h want %h", obs, e); end
  endtask

  task automatic test_soma_timing();
    logic [DW-1:0] prev;
    logic [DW-1:0] e;
    bit seen = 0;
    prev = model(45, 38, M_IDLE);
    exp_q.push_back(model(45, 38, M_SOMA));
    set_btn(1, 1'b0);
    for (int c = 0; c < LAT + 4; c++) begin
      tick(1);
      if (mode === 3'(M_SOMA)) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL soma_mode: mode %0d want %0d", mode, M_SOMA); end
    tick(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL soma_busy: got %b want 1", busy); end
    tick(RW);
    checks++; if (obs !== prev) begin errors++; $display("FAIL soma_hold: got %h want %h", obs, prev); end
    tick(1);
    e = exp_q.pop_front();
    checks++; if (obs !== e) begin errors++; $display("FAIL soma_disp: got %h want %h", obs, e); end
    set_btn(1, 1'b1); tick(HOLD);
  endtask

  task automatic test_sub();
    logic [DW-1:0] e;
    num0 = 7'd12; num1 = 7'd57;
    exp_q.push_back(model(12, 57, M_SUB));
    press(2);
    wait_settle("sub");
    e = exp_q.pop_front();
    checks++; if (obs !== e) begin errors++; $display("FAIL sub_disp: got %h want %h", obs, e); end
    exp_q.push_back(model(12, 57, M_IDLE));
    press(2);
    wait_settle("sub_off");
    e = exp_q.pop_front();
    checks++; if (obs !== e) begin errors++; $display("FAIL sub_toggle_idle: got %h want %h mode %0d", obs, e, mode); end
  endtask

  task automatic test_mult();
    logic [DW-1:0] e;
    num0 = 7'd127; num1 = 7'd99;
    exp_q.push_back(model(127, 99, M_MULT));
    press(3);
    wait_settle("mult");
    e = exp_q.pop_front();
    checks++; if (obs !== e) begin errors++; $display("FAIL mult_disp: got %h want %h", obs, e); end
  endtask

  task automatic test_abort();
    logic [DW-1:0] old;
    logic [DW-1:0] e;
    logic [DW-1:0] fin;
    int quiet = 0;
    bit bad = 0;
    bit ok = 0;
    old = model(127, 99, M_MULT);
    num1 = 7'd50;
    wait_busy("abort");
    tick(3);
    num1 = 7'd20;
    fin = model(127, 20, M_MULT);
    exp_q.push_back(fin);
    for (int c = 0; c < 400; c++) begin
      tick(1);
      if (obs !== old && obs !== fin) bad = 1;
      if (busy === 1'b0) quiet++; else quiet = 0;
      if (quiet >= 4) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL abort_settle: busy did not stay low within 400 cycles"); end
    checks++; if (bad) begin errors++; $display("FAIL abort_intermediate: display showed a value other than %h or %h", old, fin); end
    e = exp_q.pop_front();
    checks++; if (obs !== e) begin errors++; $display("FAIL abort_final: got %h want %h", obs, e); end
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 3; g++) begin
      set_btn(1, 1'b0); tick(2);
      set_btn(1, 1'b1); tick(4);
    end
    tick(LAT + 4);
    checks++; if (mode !== 3'(GLITCH_MODE)) begin errors++; $display("FAIL glitch_mode: got %0d want %0d", mode, GLITCH_MODE); end
    wait_settle("glitch");
  endtask

  task automatic test_off();
    bit seen = 0;
    num0 = 7'd30;
    wait_busy("off");
    set_btn(0, 1'b0);
    for (int c = 0; c < LAT + 4; c++) begin
      tick(1);
      if (mode === 3'(M_OFF)) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL off_mode: got %0d want %0d", mode, M_OFF); end
    tick(1);
    checks++; if (obs !== '1) begin errors++; $display("FAIL off_blank: got %h want all ones", obs); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL off_busy: got %b want 0", busy); end
    set_btn(0, 1'b1); tick(HOLD + RW);
    checks++; if (obs !== '1) begin errors++; $display("FAIL off_discard: got %h want all ones", obs); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    exp_q.push_back(model(30, 20, M_IDLE));
    press(0);
    wait_settle("reidle");
    e = exp_q.pop_front();
    checks++; if (obs !== e) begin errors++; $display("FAIL reidle_disp: got %h want %h", obs, e); end
    num1 = 7'd7;
    wait_busy("rstmid");
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs !== '1) begin errors++; $display("FAIL rstmid_blank: got %h want all ones", obs); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (mode !== 3'(M_OFF)) begin errors++; $display("FAIL rstmid_mode: got %0d want %0d", mode, M_OFF); end
    tick(2);
    rst_n = 1'b1;
    tick(6);
    checks++; if (mode !== 3'(M_OFF)) begin errors++; $display("FAIL rstmid_after: mode %0d want %0d", mode, M_OFF); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_power_latency();
    test_soma_timing();
    test_sub();
    test_mult();
    test_abort();
    test_glitch();
    test_off();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
